// File: rtl/prio_arb_seq_if.sv
// Request/grant bundle between N requesters and the priority arbiter.
// The arbiter uses the slave modport; the requester side uses the master modport.
interface prio_arb_seq_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic             gnt_ack;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [N-1:0]     gnt_onehot;
  logic             busy;

  modport master (
    output req, gnt_ack,
    input  gnt_vld, gnt_idx, gnt_onehot, busy
  );

  modport slave (
    input  req, gnt_ack,
    output gnt_vld, gnt_idx, gnt_onehot, busy
  );
endinterface

// File: rtl/prio_arb_seq.sv
// Registered N-way priority arbiter with a sticky valid/ack grant.
// MODE 0 is fixed priority, where the highest index wins; MODE 1 is round-robin from the last acked index.
module prio_arb_seq #(
  parameter int unsigned N    = 8,
  parameter int unsigned MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  prio_arb_seq_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [N-1:0]     r_gnt_onehot;
  logic [IDX_W-1:0] r_last;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_gnt_idx_nxt;
  logic [N-1:0]     w_gnt_onehot_nxt;
  logic [IDX_W-1:0] w_last_nxt;

  logic             w_accept;
  logic             w_any_req;
  logic [IDX_W-1:0] w_last_eff;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_win;
  logic [IDX_W-1:0] w_pos;
  int               w_t;

  assign w_accept   = (r_state == GRANT) && bus.gnt_ack;
  assign w_any_req  = |bus.req;
  // A grant accepted this cycle moves the round-robin pointer before the re-arbitration.
  assign w_last_eff = w_accept ? r_gnt_idx : r_last;
  assign w_start    = (w_last_eff == '0) ? IDX_W'(N - 1) : w_last_eff - IDX_W'(1);

  // Winner search; a later loop iteration overrides an earlier one, so the preferred candidate is visited last.
  always_comb begin
    w_win = '0;
    w_pos = '0;
    w_t   = 0;
    if (MODE == 0) begin
      for (int i = 0; i < int'(N); i++) begin
        w_pos = IDX_W'(i);
        if (bus.req[w_pos]) w_win = w_pos;
      end
    end else begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        w_t   = (int'(w_start) + int'(N) - k) % int'(N);
        w_pos = IDX_W'(w_t);
        if (bus.req[w_pos]) w_win = w_pos;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_gnt_idx_nxt    = r_gnt_idx;
    w_gnt_onehot_nxt = r_gnt_onehot;
    w_last_nxt       = r_last;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt      = GRANT;
          w_gnt_idx_nxt    = w_win;
          w_gnt_onehot_nxt = N'(1) << w_win;
        end
      end
      GRANT: begin
        if (bus.gnt_ack) begin
          w_last_nxt = r_gnt_idx;
          if (w_any_req) begin
            w_gnt_idx_nxt    = w_win;
            w_gnt_onehot_nxt = N'(1) << w_win;
          end else begin
            w_state_nxt      = IDLE;
            w_gnt_idx_nxt    = '0;
            w_gnt_onehot_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt      = IDLE;
        w_gnt_idx_nxt    = '0;
        w_gnt_onehot_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
      r_last       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt_idx    <= w_gnt_idx_nxt;
      r_gnt_onehot <= w_gnt_onehot_nxt;
      r_last       <= w_last_nxt;
    end
  end

  assign bus.gnt_vld    = (r_state == GRANT);
  assign bus.busy       = (r_state == GRANT);
  assign bus.gnt_idx    = r_gnt_idx;
  assign bus.gnt_onehot = r_gnt_onehot;
endmodule

// File: tb/tb_prio_arb_seq.sv
// Directed scoreboard bench for prio_arb_seq.
// It covers fixed priority with N=8 and round-robin with N=8 and N=5.
module tb_prio_arb_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prio_arb_seq_if #(.N(8)) if0 ();
  prio_arb_seq_if #(.N(8)) if1 ();
  prio_arb_seq_if #(.N(5)) if2 ();

  prio_arb_seq #(.N(8), .MODE(0)) u_fix8 (.clk(clk), .rst(rst), .bus(if0.slave));
  prio_arb_seq #(.N(8), .MODE(1)) u_rr8  (.clk(clk), .rst(rst), .bus(if1.slave));
  prio_arb_seq #(.N(5), .MODE(1)) u_rr5  (.clk(clk), .rst(rst), .bus(if2.slave));

  typedef struct {
    string      tag;
    int         sel;
    logic       vld;
    logic [2:0] idx;
    logic [7:0] oh;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int sel, input logic vld,
                            input logic [2:0] idx, input logic [7:0] oh);
    exp_t e;
    e.tag = tag; e.sel = sel; e.vld = vld; e.idx = idx; e.oh = oh;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the selected DUT: {busy, vld, idx, onehot}.
  task automatic check_out();
    exp_t        e;
    logic [12:0] obs;
    logic [12:0] exp_v;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty observed=no-expectation expected=queued-entry");
    end else begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = {if0.busy, if0.gnt_vld, if0.gnt_idx, if0.gnt_onehot};
        1:       obs = {if1.busy, if1.gnt_vld, if1.gnt_idx, if1.gnt_onehot};
        default: obs = {if2.busy, if2.gnt_vld, if2.gnt_idx, 3'b000, if2.gnt_onehot};
      endcase
      exp_v = {e.vld, e.vld, e.idx, e.oh};
      assert (obs === exp_v) else begin
        n_err++;
        $error("FAIL %s observed busy/vld/idx/oh=%b/%b/%0d/%h expected=%b/%b/%0d/%h",
               e.tag, obs[12], obs[11], obs[10:8], obs[7:0],
               exp_v[12], exp_v[11], exp_v[10:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic exp_step(input string tag, input int sel, input logic vld,
                          input logic [2:0] idx, input logic [7:0] oh);
    expect_out(tag, sel, vld, idx, oh);
    step();
    check_out();
  endtask

  initial begin
    if0.req = '0; if0.gnt_ack = 1'b0;
    if1.req = '0; if1.gnt_ack = 1'b0;
    if2.req = '0; if2.gnt_ack = 1'b0;

    // Reset state.
    step(); step();
    expect_out("rst_fix8", 0, 1'b0, 3'd0, 8'h00); check_out();
    expect_out("rst_rr8",  1, 1'b0, 3'd0, 8'h00); check_out();
    expect_out("rst_rr5",  2, 1'b0, 3'd0, 8'h00); check_out();
    rst = 1'b0;
    exp_step("idle_noreq", 0, 1'b0, 3'd0, 8'h00);

    // T1: fixed priority, sticky hold, and back-to-back grants.
    if0.req = 8'b0010_0100;
    exp_step("t1_first", 0, 1'b1, 3'd5, 8'h20);
    if0.req = 8'h81;
    exp_step("t1_hold1", 0, 1'b1, 3'd5, 8'h20);
    exp_step("t1_hold2", 0, 1'b1, 3'd5, 8'h20);
    exp_step("t1_hold3", 0, 1'b1, 3'd5, 8'h20);
    if0.req = 8'h04; if0.gnt_ack = 1'b1;
    exp_step("t1_b2b", 0, 1'b1, 3'd2, 8'h04);
    exp_step("t1_regrant", 0, 1'b1, 3'd2, 8'h04);
    if0.req = 8'h00;
    exp_step("t1_idle", 0, 1'b0, 3'd0, 8'h00);
    if0.gnt_ack = 1'b0;

    // T2: round-robin rotation for N=8 with all requesters active.
    if1.req = 8'hFF;
    exp_step("t2_g7", 1, 1'b1, 3'd7, 8'h80);
    if1.gnt_ack = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      exp_step("t2_rot", 1, 1'b1, 3'(i), 8'h01 << i);
    end
    exp_step("t2_wrap7", 1, 1'b1, 3'd7, 8'h80);

    // T6: an ack while idle must not move the pointer (last = 7 here).
    if1.req = 8'h00;
    exp_step("t6_to_idle", 1, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 4; i++) exp_step("t6_stray", 1, 1'b0, 3'd0, 8'h00);
    if1.gnt_ack = 1'b0; if1.req = 8'hFF;
    exp_step("t6_ptr", 1, 1'b1, 3'd6, 8'h40);

    // T3: round-robin with N=5, wrapping at a non-power-of-two width.
    if2.req = 5'b10001;
    exp_step("t3_g4a", 2, 1'b1, 3'd4, 8'h10);
    if2.gnt_ack = 1'b1;
    exp_step("t3_g0a", 2, 1'b1, 3'd0, 8'h01);
    exp_step("t3_g4b", 2, 1'b1, 3'd4, 8'h10);
    exp_step("t3_g0b", 2, 1'b1, 3'd0, 8'h01);
    if2.req = 5'b00000;
    exp_step("t3_idle", 2, 1'b0, 3'd0, 8'h00);
    if2.gnt_ack = 1'b0;

    // T4: the grant stays sticky after its request drops.
    if0.req = 8'h80;
    exp_step("t4_g7", 0, 1'b1, 3'd7, 8'h80);
    if0.req = 8'h00;
    exp_step("t4_hold1", 0, 1'b1, 3'd7, 8'h80);
    exp_step("t4_hold2", 0, 1'b1, 3'd7, 8'h80);
    if0.gnt_ack = 1'b1;
    exp_step("t4_release", 0, 1'b0, 3'd0, 8'h00);
    if0.gnt_ack = 1'b0;

    // T5: asynchronous reset asserted between edges while a grant is outstanding (last = 6).
    if1.gnt_ack = 1'b1;
    exp_step("t5_pre", 1, 1'b1, 3'd5, 8'h20);
    if1.gnt_ack = 1'b0;
    if0.req = 8'h01;
    exp_step("t5_fix_g0", 0, 1'b1, 3'd0, 8'h01);
    #2 rst = 1'b1;
    #1;
    expect_out("t5_async_rr8",  1, 1'b0, 3'd0, 8'h00); check_out();
    expect_out("t5_async_fix8", 0, 1'b0, 3'd0, 8'h00); check_out();
    if0.req = 8'h00;
    step();
    rst = 1'b0;
    exp_step("t5_restart", 1, 1'b1, 3'd7, 8'h80);
    if1.gnt_ack = 1'b1;
    exp_step("t5_next", 1, 1'b1, 3'd6, 8'h40);
    if1.req = 8'h00;
    exp_step("t5_idle", 1, 1'b0, 3'd0, 8'h00);
    if1.gnt_ack = 1'b0;

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
